fp_operand_entry: RTL and testbench

//  Front-end control stage placed directly upstream of the fpadder core on the board.

---
 rtl/fp_operand_entry.sv | 168 ++++++++++++++++
 tb/tb_fp_operand_entry.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_entry.sv
// Board front end for the fpadder: conditions the push-buttons and switches,
// latches operands on a start press and fires a one-cycle start pulse.
module fp_operand_entry #(
    parameter int W               = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         btn_start,
    input  logic         btn_show,
    input  logic [W-1:0] sw_a,
    input  logic [W-1:0] sw_b,
    input  logic         adder_busy,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         start,
    output logic         show_sum,
    output logic         entry_busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FIRE    = 2'd2,
        WAIT    = 2'd3
    } state_t;

    // Returns {next_level, next_count}; the level follows the input only after
    // DEBOUNCE_CYCLES consecutive disagreeing samples.
    function automatic logic [CW:0] debounce_next(input logic          synced,
                                                  input logic          level,
                                                  input logic [CW-1:0] cnt);
        logic [CW:0] nxt;
        if (synced == level) begin
            nxt = {level, {CW{1'b0}}};
        end else if (cnt == CNT_LAST) begin
            nxt = {synced, {CW{1'b0}}};
        end else begin
            nxt = {level, cnt + CW'(1)};
        end
        return nxt;
    endfunction

    logic [1:0]    start_sync_q, start_sync_d;
    logic [1:0]    show_sync_q, show_sync_d;
    logic [W-1:0]  sw_a_sync1_q, sw_a_sync1_d, sw_a_sync2_q, sw_a_sync2_d;
    logic [W-1:0]  sw_b_sync1_q, sw_b_sync1_d, sw_b_sync2_q, sw_b_sync2_d;
    logic [CW-1:0] start_cnt_q, start_cnt_d, show_cnt_q, show_cnt_d;
    logic          start_deb_q, start_deb_d, show_deb_q, show_deb_d;
    logic          start_prev_q, start_prev_d, show_prev_q, show_prev_d;
    logic          start_press_q, start_press_d, show_press_q, show_press_d;
    state_t        state_q, state_d;
    logic [W-1:0]  a_out_q, a_out_d, b_out_q, b_out_d;
    logic          start_q, start_d;
    logic          show_sum_q, show_sum_d;
    logic          entry_busy_q, entry_busy_d;

    // Next-state logic for the conditioning pipeline, the FSM and its outputs.
    always_comb begin
        start_sync_d = {start_sync_q[0], btn_start};
        show_sync_d  = {show_sync_q[0], btn_show};
        sw_a_sync1_d = sw_a;
        sw_a_sync2_d = sw_a_sync1_q;
        sw_b_sync1_d = sw_b;
        sw_b_sync2_d = sw_b_sync1_q;

        {start_deb_d, start_cnt_d} = debounce_next(start_sync_q[1], start_deb_q, start_cnt_q);
        {show_deb_d, show_cnt_d}   = debounce_next(show_sync_q[1], show_deb_q, show_cnt_q);

        start_prev_d  = start_deb_q;
        show_prev_d   = show_deb_q;
        start_press_d = start_deb_q & ~start_prev_q;
        show_press_d  = show_deb_q & ~show_prev_q;

        state_d = state_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        case (state_q)
            IDLE: begin
                // A press during busy is simply lost, never queued.
                if (start_press_q && !adder_busy) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                a_out_d = sw_a_sync2_q;
                b_out_d = sw_b_sync2_q;
                state_d = FIRE;
            end
            FIRE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (adder_busy) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d      = (state_d == FIRE);
        entry_busy_d = (state_d != IDLE);
        show_sum_d   = show_sum_q ^ show_press_q;
    end

    // All state registers, with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            start_sync_q  <= 2'b00;
            show_sync_q   <= 2'b00;
            sw_a_sync1_q  <= '0;
            sw_a_sync2_q  <= '0;
            sw_b_sync1_q  <= '0;
            sw_b_sync2_q  <= '0;
            start_cnt_q   <= '0;
            show_cnt_q    <= '0;
            start_deb_q   <= 1'b0;
            show_deb_q    <= 1'b0;
            start_prev_q  <= 1'b0;
            show_prev_q   <= 1'b0;
            start_press_q <= 1'b0;
            show_press_q  <= 1'b0;
            state_q       <= IDLE;
            a_out_q       <= '0;
            b_out_q       <= '0;
            start_q       <= 1'b0;
            show_sum_q    <= 1'b0;
            entry_busy_q  <= 1'b0;
        end else begin
            start_sync_q  <= start_sync_d;
            show_sync_q   <= show_sync_d;
            sw_a_sync1_q  <= sw_a_sync1_d;
            sw_a_sync2_q  <= sw_a_sync2_d;
            sw_b_sync1_q  <= sw_b_sync1_d;
            sw_b_sync2_q  <= sw_b_sync2_d;
            start_cnt_q   <= start_cnt_d;
            show_cnt_q    <= show_cnt_d;
            start_deb_q   <= start_deb_d;
            show_deb_q    <= show_deb_d;
            start_prev_q  <= start_prev_d;
            show_prev_q   <= show_prev_d;
            start_press_q <= start_press_d;
            show_press_q  <= show_press_d;
            state_q       <= state_d;
            a_out_q       <= a_out_d;
            b_out_q       <= b_out_d;
            start_q       <= start_d;
            show_sum_q    <= show_sum_d;
            entry_busy_q  <= entry_busy_d;
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign start      = start_q;
    assign show_sum   = show_sum_q;
    assign entry_busy = entry_busy_q;

endmodule

// File: tb/tb_fp_operand_entry.sv
// Directed and randomized bench for fp_operand_entry against an event-level
// reference model (run-length debounce, press schedule, operation timeline).
module tb_fp_operand_entry;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         clr, btn_start, btn_show, adder_busy;
    logic [W-1:0] sw_a, sw_b;
    logic [W-1:0] a_out, b_out;
    logic         start, show_sum, entry_busy;

    always #5 clk = ~clk;

    fp_operand_entry #(.W(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .clr(clr), .btn_start(btn_start), .btn_show(btn_show),
        .sw_a(sw_a), .sw_b(sw_b), .adder_busy(adder_busy),
        .a_out(a_out), .b_out(b_out), .start(start),
        .show_sum(show_sum), .entry_busy(entry_busy)
    );

    int total = 0;
    int bad   = 0;
    int edge_no = 0;
    int starts_seen = 0;

    // reference model state
    logic         m_s1_st = 1'b0, m_s2_st = 1'b0, m_s1_sh = 1'b0, m_s2_sh = 1'b0;
    logic         m_lvl_st = 1'b0, m_lvl_sh = 1'b0;
    int           m_run_st = 0, m_run_sh = 0;
    logic [W-1:0] m_a1 = '0, m_a2 = '0, m_b1 = '0, m_b2 = '0, m_a = '0, m_b = '0;
    logic         m_show = 1'b0, m_start = 1'b0;
    bit           m_in_op = 1'b0;
    int           m_e = 0;
    int           st_due[$];
    int           sh_due[$];

    // external adder behaviour
    int add_len = 2;
    int add_left = 0;
    bit add_pend = 1'b0;
    bit force_busy = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Level follows the synced input once it has disagreed for DC samples in a row.
    task automatic debounce_model(input logic syn, inout logic lvl, inout int run, output bit rose);
        rose = 1'b0;
        if (syn == lvl) begin
            run = 0;
        end else begin
            run++;
            if (run == DC) begin
                lvl  = syn;
                run  = 0;
                rose = syn;
            end
        end
    endtask

    task automatic model_edge();
        bit acc;
        bit rose_st, rose_sh;
        int k;
        k = edge_no;
        acc = 1'b0;
        m_start = 1'b0;
        if (!clr) begin
            m_s1_st = 0; m_s2_st = 0; m_s1_sh = 0; m_s2_sh = 0;
            m_lvl_st = 0; m_lvl_sh = 0; m_run_st = 0; m_run_sh = 0;
            m_a1 = '0; m_a2 = '0; m_b1 = '0; m_b2 = '0; m_a = '0; m_b = '0;
            m_show = 0; m_in_op = 0;
            st_due.delete();
            sh_due.delete();
        end else begin
            if (st_due.size() > 0 && st_due[0] == k) begin
                void'(st_due.pop_front());
                acc = !m_in_op && !adder_busy;
            end
            if (m_in_op) begin
                if (k == m_e + 1) begin
                    m_a = m_a2;
                    m_b = m_b2;
                    m_start = 1'b1;
                end
                if (k >= m_e + 3 && !adder_busy) m_in_op = 1'b0;
            end else if (acc) begin
                m_in_op = 1'b1;
                m_e = k;
            end
            if (sh_due.size() > 0 && sh_due[0] == k) begin
                void'(sh_due.pop_front());
                m_show = ~m_show;
            end
            debounce_model(m_s2_st, m_lvl_st, m_run_st, rose_st);
            debounce_model(m_s2_sh, m_lvl_sh, m_run_sh, rose_sh);
            if (rose_st) st_due.push_back(k + 2);
            if (rose_sh) sh_due.push_back(k + 2);
            m_s2_st = m_s1_st; m_s1_st = btn_start;
            m_s2_sh = m_s1_sh; m_s1_sh = btn_show;
            m_a2 = m_a1; m_a1 = sw_a;
            m_b2 = m_b1; m_b1 = sw_b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        check("a_out", a_out, m_a);
        check("b_out", b_out, m_b);
        check("start", {7'd0, start}, {7'd0, m_start});
        check("show_sum", {7'd0, show_sum}, {7'd0, m_show});
        check("entry_busy", {7'd0, entry_busy}, {7'd0, m_in_op});
        if (start === 1'b1) starts_seen++;
        if (add_left > 0) add_left--;
        if (add_pend) begin
            add_left = add_len;
            add_pend = 1'b0;
        end
        if (start === 1'b1) add_pend = 1'b1;
        adder_busy = force_busy || (add_left > 0);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int s0, first_edge, lat, n, hold;

    initial begin
        clr = 1'b0; btn_start = 1'b1; btn_show = 1'b1;
        sw_a = 8'h00; sw_b = 8'h00; adder_busy = 1'b0;

        // 1: reset with buttons high, then release and stay quiet
        run(3);
        check("rst_a", a_out, 8'h00);
        check("rst_start", {7'd0, start}, 8'h00);
        check("rst_show", {7'd0, show_sum}, 8'h00);
        check("rst_busy", {7'd0, entry_busy}, 8'h00);
        clr = 1'b1; btn_start = 1'b0; btn_show = 1'b0;
        s0 = starts_seen;
        run(20);
        check("rst_no_start", 8'(starts_seen - s0), 8'd0);

        // 2: clean held press, latency counted with the sampling edge as edge 1
        sw_a = 8'h3C; sw_b = 8'h41; btn_start = 1'b1;
        first_edge = edge_no + 1;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start === 1'b1 && lat < 0) lat = edge_no - first_edge + 1;
        end
        check("latency", 8'(lat), 8'd9);
        check("cap_a", a_out, 8'h3C);
        check("cap_b", b_out, 8'h41);
        btn_start = 1'b0;
        run(12);

        // 3: bouncing press never qualifies
        s0 = starts_seen;
        btn_start = 1'b1; run(3);
        btn_start = 1'b0; run(2);
        btn_start = 1'b1; run(3);
        btn_start = 1'b0; run(15);
        check("bounce_no_start", 8'(starts_seen - s0), 8'd0);

        // 4: press while busy is dropped, later press fires once
        force_busy = 1'b1; adder_busy = 1'b1;
        s0 = starts_seen;
        btn_start = 1'b1; run(8);
        btn_start = 1'b0; run(8);
        check("busy_drop", 8'(starts_seen - s0), 8'd0);
        check("busy_idle", {7'd0, entry_busy}, 8'h00);
        force_busy = 1'b0; adder_busy = 1'b0;
        run(2);
        btn_start = 1'b1; run(10);
        btn_start = 1'b0; run(12);
        check("after_busy_one", 8'(starts_seen - s0), 8'd1);

        // 5: switch change during WAIT is not captured
        add_len = 8;
        sw_a = 8'h3C; sw_b = 8'h41;
        btn_start = 1'b1; run(10);
        btn_start = 1'b0; sw_a = 8'hFF;
        run(3);
        check("hold_wait_busy", {7'd0, entry_busy}, 8'h01);
        check("hold_a", a_out, 8'h3C);
        run(14);
        check("hold_a_idle", a_out, 8'h3C);
        btn_start = 1'b1; run(10);
        btn_start = 1'b0; run(14);
        check("recap_a", a_out, 8'hFF);
        add_len = 2;

        // 6: three show presses, the second together with a start press
        s0 = starts_seen;
        btn_show = 1'b1; run(8); btn_show = 1'b0; run(8);
        btn_show = 1'b1; btn_start = 1'b1; run(8);
        btn_show = 1'b0; btn_start = 1'b0; run(8);
        btn_show = 1'b1; run(8); btn_show = 1'b0; run(8);
        check("show_final", {7'd0, show_sum}, 8'h01);
        check("show_start", 8'(starts_seen - s0), 8'd1);

        // randomized segments, including mid-operation resets
        for (int seg = 0; seg < 300; seg++) begin
            btn_start  = 1'($urandom_range(0, 1));
            btn_show   = 1'($urandom_range(0, 1));
            sw_a       = 8'($urandom);
            sw_b       = 8'($urandom);
            force_busy = ($urandom_range(0, 7) == 0);
            add_len    = $urandom_range(0, 4);
            adder_busy = force_busy || (add_left > 0);
            clr        = ($urandom_range(0, 29) != 0);
            hold       = clr ? $urandom_range(1, 9) : $urandom_range(1, 3);
            run(hold);
            clr = 1'b1;
        end
        force_busy = 1'b0; btn_start = 1'b0; btn_show = 1'b0;
        n = 20;
        run(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
